// File: rtl/pattern_player_pkg.sv
// pattern_player_pkg
//   Shared game definitions: difficulty level encodings, pattern lengths,
//   LFSR seed, FSM state encoding and small helpers used by the player.
package pattern_player_pkg;

    localparam logic [2:0] LVL_LOW  = 3'b001;
    localparam logic [2:0] LVL_MID  = 3'b010;
    localparam logic [2:0] LVL_HIGH = 3'b100;

    localparam logic [3:0] LEN_LOW  = 4'd4;
    localparam logic [3:0] LEN_MID  = 4'd6;
    localparam logic [3:0] LEN_HIGH = 4'd8;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ON   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Pattern length for a level; 0 marks an invalid (non one-hot) level.
    function automatic logic [3:0] level_len(input logic [2:0] lvl);
        case (lvl)
            LVL_LOW:  return LEN_LOW;
            LVL_MID:  return LEN_MID;
            LVL_HIGH: return LEN_HIGH;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/pattern_player_lfsr8.sv
// lfsr8
//   8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length,
//   never reaches all-zero from a non-zero seed).
//   i_clk     : clock
//   i_rst_n   : asynchronous active-low reset, loads SEED
//   i_advance : shift one step on this edge
//   o_value   : low OUT_BITS bits of the register
module lfsr8
    import pattern_player_pkg::*;
#(
    parameter logic [7:0]  SEED     = LFSR_SEED,
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_advance,
    output logic [OUT_BITS-1:0] o_value
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb    = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign o_value = r_q[OUT_BITS-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= SEED;
        end else if (i_advance) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

endmodule

// File: rtl/pattern_player.sv
// pattern_player
//   Generates a random round pattern (4/6/8 entries of 0..7, no adjacent
//   repeats) and plays it on a one-hot LED bus, each step ON then all-off GAP.
//   clk_1   : system clock
//   rst     : asynchronous active-low reset
//   start   : one-cycle request to generate and play a pattern
//   level   : one-hot difficulty (001 low, 010 mid, 100 high)
//   abort   : stop playback at the next edge
//   rd_addr : pattern read address for the input checker
//   led     : one-hot LED drive
//   rd_idx  : stored entry at rd_addr (combinational)
//   pat_len : current pattern length
//   busy    : high outside IDLE
//   done    : one-cycle pulse at playback completion
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter int unsigned ON_TICKS  = 50_000_000,
    parameter int unsigned GAP_TICKS = 25_000_000
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] level,
    input  logic       abort,
    input  logic [2:0] rd_addr,
    output logic [7:0] led,
    output logic [2:0] rd_idx,
    output logic [3:0] pat_len,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    // Halved ON time is clamped to one cycle so a step is never empty.
    localparam int unsigned ON_HALF   = (ON_TICKS / 2 > 0) ? ON_TICKS / 2 : 1;

    localparam logic [TW-1:0] ON_LAST      = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] ON_HALF_LAST = TW'(ON_HALF - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_TICKS - 1);

    state_t          r_state;
    logic [7:0]      r_led;
    logic [3:0]      r_len;
    logic [3:0]      r_step;
    logic [TW-1:0]   r_tick;
    logic            r_fast;
    logic [2:0]      r_pat [8];

    logic [2:0]      w_cand;
    logic [2:0]      w_prev_addr;
    logic [2:0]      w_entry;
    logic [TW-1:0]   w_on_last;
    logic [3:0]      w_req_len;

    lfsr8 #(
        .SEED     (LFSR_SEED),
        .OUT_BITS (3)
    ) u_lfsr (
        .i_clk     (clk_1),
        .i_rst_n   (rst),
        .i_advance (1'b1),
        .o_value   (w_cand)
    );

    assign w_prev_addr = r_step[2:0] - 3'd1;
    assign w_entry     = ((r_step != 4'd0) && (w_cand == r_pat[w_prev_addr]))
                         ? w_cand + 3'd1 : w_cand;
    assign w_on_last   = r_fast ? ON_HALF_LAST : ON_LAST;
    assign w_req_len   = level_len(level);

    assign led     = r_led;
    assign rd_idx  = r_pat[rd_addr];
    assign pat_len = r_len;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);

    // led is registered from the current state, so it trails the state by one
    // edge: entry 0 appears one cycle after LOAD finishes and each ON/GAP
    // window is still exactly its tick count long.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_led   <= '0;
            r_len   <= '0;
            r_step  <= '0;
            r_tick  <= '0;
            r_fast  <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_pat[i] <= '0;
            end
        end else if (abort && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_led   <= '0;
            r_step  <= '0;
            r_tick  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_led <= '0;
                    if (start && !abort && (w_req_len != 4'd0)) begin
                        r_len   <= w_req_len;
                        r_fast  <= (level == LVL_HIGH);
                        r_step  <= '0;
                        r_tick  <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_pat[r_step[2:0]] <= w_entry;
                    if (r_step == r_len - 4'd1) begin
                        r_step  <= '0;
                        r_tick  <= '0;
                        r_state <= ST_ON;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                ST_ON: begin
                    r_led <= onehot8(r_pat[r_step[2:0]]);
                    if (r_tick == w_on_last) begin
                        r_tick  <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_led <= '0;
                    if (r_tick == GAP_LAST) begin
                        r_tick <= '0;
                        if (r_step == r_len - 4'd1) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_step  <= r_step + 4'd1;
                            r_state <= ST_ON;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_led   <= '0;
                    r_step  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_led   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player
//   Directed bench for pattern_player with ON_TICKS=4, GAP_TICKS=2.
//   Expected patterns come from an independent LFSR reference and the
//   number of clock edges since reset release.
module tb_pattern_player;

    localparam int ON_T  = 4;
    localparam int GAP_T = 2;

    logic       clk_1   = 1'b0;
    logic       rst     = 1'b0;
    logic       start   = 1'b0;
    logic [2:0] level   = 3'b001;
    logic       abort   = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] led;
    logic [2:0] rd_idx;
    logic [3:0] pat_len;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned n_edges;
    logic [2:0]  exp_pat [8];

    always #5 clk_1 = ~clk_1;

    // Edges seen since reset release; the DUT LFSR has advanced this many times.
    always @(posedge clk_1 or negedge rst) begin
        if (!rst) n_edges <= 0;
        else      n_edges <= n_edges + 1;
    end

    pattern_player #(
        .ON_TICKS  (ON_T),
        .GAP_TICKS (GAP_T)
    ) dut (
        .clk_1   (clk_1),
        .rst     (rst),
        .start   (start),
        .level   (level),
        .abort   (abort),
        .rd_addr (rd_addr),
        .led     (led),
        .rd_idx  (rd_idx),
        .pat_len (pat_len),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_after(input int unsigned n);
        logic [7:0] q;
        q = 8'hA5;
        for (int unsigned i = 0; i < n; i++) begin
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
        return q;
    endfunction

    function automatic int len_of(input logic [2:0] lvl);
        case (lvl)
            3'b001:  return 4;
            3'b010:  return 6;
            3'b100:  return 8;
            default: return 0;
        endcase
    endfunction

    // e = edges before the start-sampling edge; entry i uses the LFSR value
    // held during the i-th LOAD cycle, i.e. after e+1+i advances.
    task automatic build_exp(input int unsigned e, input int pl);
        logic [7:0] q;
        logic [2:0] v;
        for (int i = 0; i < pl; i++) begin
            q = lfsr_after(e + 1 + i);
            v = q[2:0];
            if (i > 0 && v == exp_pat[i-1]) v = v + 3'd1;
            exp_pat[i] = v;
        end
    endtask

    task automatic check_cycle(input int c, input int pl, input int on_len);
        int         per;
        int         t;
        int         s;
        int         r;
        int         last;
        logic [7:0] el;
        per  = on_len + GAP_T;
        last = pl + pl * per;
        el   = 8'h00;
        if (c >= pl + 1) begin
            t = c - pl - 1;
            s = t / per;
            r = t % per;
            if (s < pl && r < on_len) el = 8'h01 << exp_pat[s];
        end
        chk($sformatf("led c%0d", c),  {24'd0, led}, {24'd0, el});
        chk($sformatf("busy c%0d", c), {31'd0, busy}, {31'd0, (c <= last)});
        chk($sformatf("done c%0d", c), {31'd0, done}, {31'd0, (c == last)});
    endtask

    // Starts a round and checks every cycle. inj: cycle at which a second
    // start is pulsed (-1 none). stop_c: stop early at that cycle (-1 full).
    task automatic play(input logic [2:0] lvl, input int inj, input int stop_c);
        int         pl;
        int         on_len;
        int         last;
        int         end_c;
        logic [2:0] prev;
        pl     = len_of(lvl);
        on_len = (lvl == 3'b100) ? ON_T / 2 : ON_T;
        last   = pl + pl * (on_len + GAP_T);
        end_c  = (stop_c >= 0) ? stop_c : last + 2;
        @(negedge clk_1);
        level = lvl;
        start = 1'b1;
        build_exp(n_edges, pl);
        @(posedge clk_1);
        #1;
        start = 1'b0;
        for (int c = 0; c <= end_c; c++) begin
            if (c > 0) begin
                @(posedge clk_1);
                #1;
            end
            check_cycle(c, pl, on_len);
            if (c >= 1 && c <= pl) begin
                rd_addr = 3'(c - 1);
                #1;
                chk($sformatf("load_rd c%0d", c), {29'd0, rd_idx}, {29'd0, exp_pat[c-1]});
            end
            start = (c == inj);
        end
        start = 1'b0;
        if (stop_c < 0) begin
            chk("pat_len", {28'd0, pat_len}, 32'(pl));
            prev = 3'd0;
            for (int i = 0; i < pl; i++) begin
                rd_addr = 3'(i);
                #1;
                chk($sformatf("rd_idx[%0d]", i), {29'd0, rd_idx}, {29'd0, exp_pat[i]});
                if (i > 0) chk($sformatf("adj[%0d]", i), {31'd0, (rd_idx != prev)}, 32'd1);
                prev = rd_idx;
            end
        end
    endtask

    task automatic try_ignored(input logic [2:0] lvl, input logic ab, input int want_len);
        @(negedge clk_1);
        level = lvl;
        start = 1'b1;
        abort = ab;
        @(posedge clk_1);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk_1);
                #1;
            end
            chk($sformatf("ign_busy %b c%0d", lvl, c), {31'd0, busy}, 32'd0);
            chk($sformatf("ign_led %b c%0d", lvl, c), {24'd0, led}, 32'd0);
            chk($sformatf("ign_done %b c%0d", lvl, c), {31'd0, done}, 32'd0);
        end
        chk("ign_len", {28'd0, pat_len}, 32'(want_len));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_led"}, {24'd0, led}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_len"}, {28'd0, pat_len}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #0.1;
            chk($sformatf("%s_rd[%0d]", tag, i), {29'd0, rd_idx}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_1);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk_1);
        rst = 1'b1;
        repeat (4) @(negedge clk_1);

        play(3'b001, -1, -1);
        play(3'b100, -1, -1);

        try_ignored(3'b011, 1'b0, 8);
        try_ignored(3'b000, 1'b0, 8);
        try_ignored(3'b001, 1'b1, 8);

        // Abort while step 2 is lit (cycle 18 of a low-level round).
        play(3'b001, -1, 18);
        chk("abort_pre_led", {24'd0, led}, {24'd0, 8'h01 << exp_pat[2]});
        abort = 1'b1;
        @(posedge clk_1);
        #1;
        abort = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin
                @(posedge clk_1);
                #1;
            end
            chk($sformatf("abort_led c%0d", c), {24'd0, led}, 32'd0);
            chk($sformatf("abort_busy c%0d", c), {31'd0, busy}, 32'd0);
            chk($sformatf("abort_done c%0d", c), {31'd0, done}, 32'd0);
        end
        chk("abort_len", {28'd0, pat_len}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("abort_rd[%0d]", i), {29'd0, rd_idx}, {29'd0, exp_pat[i]});
        end

        play(3'b001, -1, -1);
        play(3'b010, 12, -1);

        // Reset in the GAP after step 1 of a mid-level round.
        play(3'b010, -1, 17);
        chk("gap_led", {24'd0, led}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk_1);
        rst = 1'b1;
        repeat (3) @(negedge clk_1);
        play(3'b010, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 Parameters: ON_TICKS, default 50_000_000, clk_1 cycles per LED-on step; GAP_TICKS, default 25_000_000, clk_1 cycles of all-off gap after each step.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk_1  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to generate and play a new round pattern.
REQ-006 level  input  3  one-hot difficulty: 001 low, 010 mid, 100 high; any other value is invalid.
REQ-007 abort  input  1  stop playback immediately.
REQ-008 rd_addr  input  3  read address into the stored pattern, for the input checker.
REQ-009 led  output  8  one-hot LED drive; bit k drives led_(k+1).
REQ-010 rd_idx  output  3  stored pattern entry at rd_addr, combinational read.
REQ-011 pat_len  output  4  length of the current pattern: 4, 6 or 8.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when playback completes.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, ON, GAP and DONE.
REQ-015 IDLE->LOAD on start=1 with a valid level; pat_len is latched as low 4, mid 6, high 8; start with an invalid level is ignored, with no output change.
REQ-016 start received while busy=1 SHALL be ignored.
REQ-017 An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle in all states; it is never all-zero.
REQ-018 LOAD SHALL last exactly pat_len cycles and write entry i = lfsr[2:0] on the i-th LOAD cycle; if that value equals entry i-1, it writes (value+1) mod 8 instead, so adjacent entries never repeat.
REQ-019 If start is sampled at edge k, led SHALL become one-hot of entry 0 at edge k+pat_len+1.
REQ-020 ON step duration SHALL be ON_TICKS cycles, or ON_TICKS/2 (integer floor) when level=100; GAP duration SHALL be GAP_TICKS cycles with led=0.
REQ-021 After the GAP of the last entry (index pat_len-1), the FSM SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-022 abort=1 in any busy state SHALL, at the next edge, give led=0 and state IDLE, with no done pulse; the stored pattern and pat_len are retained.
REQ-023 If abort and start are both 1 in IDLE, abort wins and start is ignored.
REQ-024 The tick counter SHALL be wide enough for max(ON_TICKS, GAP_TICKS) and reload to 0 on every phase change.
REQ-025 The step index SHALL be 4 bits and compare against pat_len-1; it does not wrap.
REQ-026 rd_idx SHALL reflect the stored entry at all times, including during LOAD, where it shows the partially written pattern.

Reset
REQ-027 On rst=0, asynchronously: state IDLE, led=0, done=0, busy=0, pat_len=0, all pattern entries 0, lfsr=8'hA5, counters 0.
REQ-028 Reset asserted mid-playback SHALL blank led within the same reset assertion, with no done pulse.

Structure
REQ-029 The shared game package SHALL hold the level encodings (001/010/100), the length constants 4/6/8 and the FSM state encoding.
REQ-030 One sub-module, lfsr8 (seed, advance, value out), SHALL be used.
REQ-031 Pattern storage SHALL be an 8x3 register array; no RAM inference.

Verification (ON_TICKS=4, GAP_TICKS=2)
REQ-032 start with level=001 at edge 10 -> LOAD during edges 11-14; led one-hot of entry 0 from edge 15 for 4 cycles; 4 steps of 6 cycles; done pulse once; pat_len=4; busy is 0 after done.
REQ-033 level=100 -> pat_len=8; each ON lasts 2 cycles; all 8 entries read via rd_addr 0-7 match the LED order; no adjacent equal entries.
REQ-034 start with level=011 or 000 -> busy stays 0, led stays 0, no done.
REQ-035 abort during the third ON step -> led=0 and busy=0 next edge; no done; a fresh start then replays normally.
REQ-036 A second start mid-playback is ignored, with timing unchanged; rst low mid-GAP -> all outputs at reset values; lfsr restarts at 8'hA5, so the pattern is reproducible against the reference model.
